// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, opcode encodings and small decode helpers.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef logic [4:0] opcode_t;

    // Only SLL and SRA are implemented today; the rest are reserved for the full ALU.
    localparam opcode_t OP_ADD = 5'b00000;
    localparam opcode_t OP_SUB = 5'b00001;
    localparam opcode_t OP_AND = 5'b00010;
    localparam opcode_t OP_OR  = 5'b00011;
    localparam opcode_t OP_SLL = 5'b00100;
    localparam opcode_t OP_SRA = 5'b00101;

    function automatic logic is_shift_op(input opcode_t op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/shift_stage_if.sv
// Request/response handshake bundle between the decode stage, shift_stage and the result mux.
interface shift_stage_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       ctrl_ALUopcode;
    logic [4:0]       ctrl_shiftamt;
    logic [WIDTH-1:0] data_operandA;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             out_illegal;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, out_ready,
        output in_ready, out_valid, data_result, out_illegal, occupancy
    );

    modport master (
        output in_valid, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, out_ready,
        input  in_ready, out_valid, data_result, out_illegal, occupancy
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational 32-bit logarithmic barrel shifter: left zero-fill or arithmetic right.
module barrel_shifter
    import alu_pkg::*;
(
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic [4:0]       shiftamt,
    input  logic             left
);

    logic [WIDTH-1:0] w_stage [0:5];
    logic [WIDTH-1:0] w_sll   [0:4];
    logic [WIDTH-1:0] w_sra   [0:4];

    assign w_stage[0] = in;

    // Stage i conditionally shifts by 2**i; the right shift is kept in its own net so it stays signed.
    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int SH = 32'sd1 << i;
        assign w_sll[i]       = w_stage[i] << SH;
        assign w_sra[i]       = $signed(w_stage[i]) >>> SH;
        assign w_stage[i + 1] = !shiftamt[i] ? w_stage[i] : (left ? w_sll[i] : w_sra[i]);
    end

    assign out = w_stage[5];

endmodule

// File: rtl/shift_stage.sv
// Registered, flow-controlled SLL/SRA stage: input register S1 feeding a 2-entry result FIFO.
module shift_stage
    import alu_pkg::OP_SLL;
    import alu_pkg::is_shift_op;
#(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    shift_stage_if.slave bus
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_operand;
    logic [4:0]       r_s1_amt;
    logic             r_s1_left;
    logic             r_s1_illegal;

    logic [WIDTH-1:0] r_fifo_data [0:1];
    logic             r_fifo_ill  [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_out_valid;
    logic             w_pop;
    logic             w_has_room;
    logic             w_push;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_op_legal;
    logic [WIDTH-1:0] w_shift_out;

    // Handshake decode; out_ready reaches in_ready combinationally so a full stage still streams.
    always_comb begin
        w_out_valid = (r_count != 2'd0);
        w_pop       = w_out_valid && bus.out_ready;
        w_has_room  = (r_count < 2'(FIFO_DEPTH)) || w_pop;
        w_push      = r_s1_valid && w_has_room;
        w_in_ready  = !r_s1_valid || w_has_room;
        w_accept    = bus.in_valid && w_in_ready;
        w_op_legal  = is_shift_op(bus.ctrl_ALUopcode);
    end

    barrel_shifter u_shifter (
        .out      (w_shift_out),
        .in       (r_s1_operand),
        .shiftamt (r_s1_amt),
        .left     (r_s1_left)
    );

    // S1 input register; an illegal opcode is captured as a zero-length shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_operand <= '0;
            r_s1_amt     <= 5'd0;
            r_s1_left    <= 1'b0;
            r_s1_illegal <= 1'b0;
        end else if (flush) begin
            r_s1_valid   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_operand <= bus.data_operandA;
            r_s1_amt     <= w_op_legal ? bus.ctrl_shiftamt : 5'd0;
            r_s1_left    <= (bus.ctrl_ALUopcode == OP_SLL);
            r_s1_illegal <= !w_op_legal;
        end else if (w_push) begin
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid   <= r_s1_valid;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_wr_ptr <= w_push ? ~r_wr_ptr : r_wr_ptr;
            r_rd_ptr <= w_pop  ? ~r_rd_ptr : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; results land here from the shifter and are only ever read back from here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_ill[i]  <= 1'b0;
            end
        end else if (w_push && !flush) begin
            r_fifo_data[r_wr_ptr] <= w_shift_out;
            r_fifo_ill[r_wr_ptr]  <= r_s1_illegal;
        end else begin
            r_fifo_data[r_wr_ptr] <= r_fifo_data[r_wr_ptr];
            r_fifo_ill[r_wr_ptr]  <= r_fifo_ill[r_wr_ptr];
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.data_result = r_fifo_data[r_rd_ptr];
    assign bus.out_illegal = r_fifo_ill[r_rd_ptr];
    assign bus.occupancy   = r_count;

endmodule

// File: tb/tb_shift_stage.sv
// Self-checking bench for shift_stage: queue-based reference model plus directed literal vectors.
module tb_shift_stage;
    import alu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    shift_stage_if bus ();

    shift_stage #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } item_t;

    item_t m_s1[$];
    item_t m_fifo[$];
    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    bit    mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic item_t compute(input logic [4:0] op, input logic [4:0] amt, input logic [31:0] a);
        item_t r;
        case (op)
            5'b00100: begin r.res = a << amt;          r.ill = 1'b0; end
            5'b00101: begin r.res = $signed(a) >>> amt; r.ill = 1'b0; end
            default:  begin r.res = a;                 r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic bit model_ready();
        return (m_s1.size() == 0) || (m_fifo.size() < 2) || (m_fifo.size() > 0 && bus.out_ready);
    endfunction

    // Reference model: one S1 slot and a two-deep result queue, updated by the handshake rules.
    bit m_pop, m_push, m_acc;
    always @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            m_s1.delete();
            m_fifo.delete();
        end else begin
            m_pop  = (m_fifo.size() > 0) && bus.out_ready;
            m_acc  = bus.in_valid && model_ready();
            m_push = (m_s1.size() > 0) && (m_fifo.size() < 2 || m_pop);
            if (m_pop) void'(m_fifo.pop_front());
            if (m_push) m_fifo.push_back(m_s1.pop_front());
            if (m_acc) m_s1.push_back(compute(bus.ctrl_ALUopcode, bus.ctrl_shiftamt, bus.data_operandA));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            chk("mon_out_valid", {31'd0, bus.out_valid}, {31'd0, m_fifo.size() != 0});
            chk("mon_occupancy", {30'd0, bus.occupancy}, 32'(m_fifo.size()));
            chk("mon_in_ready", {31'd0, bus.in_ready}, {31'd0, model_ready()});
            if (m_fifo.size() != 0) begin
                chk("mon_data_result", bus.data_result, m_fifo[0].res);
                chk("mon_out_illegal", {31'd0, bus.out_illegal}, {31'd0, m_fifo[0].ill});
            end
        end
    end

    task automatic drive_req(input logic [4:0] op, input logic [4:0] amt, input logic [31:0] a);
        bus.in_valid       = 1'b1;
        bus.ctrl_ALUopcode = op;
        bus.ctrl_shiftamt  = amt;
        bus.data_operandA  = a;
    endtask

    // Single op into an idle stage; result must appear exactly one edge after the accept edge.
    task automatic send_op(input string name, input logic [4:0] op, input logic [4:0] amt,
                           input logic [31:0] a, input logic [31:0] exp_res, input logic exp_ill);
        @(posedge clock); #1;
        drive_req(op, amt, a);
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk({name, "_not_yet_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(posedge clock); #1;
        chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_result"}, bus.data_result, exp_res);
        chk({name, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, exp_ill});
    endtask

    logic [4:0]  t_op  [0:7] = '{5'b00100, 5'b00101, 5'b00000, 5'b00101, 5'b00100, 5'b11111, 5'b00101, 5'b00100};
    logic [4:0]  t_amt [0:7] = '{5'd1, 5'd4, 5'd9, 5'd31, 5'd16, 5'd3, 5'd0, 5'd31};
    logic [31:0] t_a   [0:7] = '{32'hDEADBEEF, 32'h80000010, 32'hCAFEF00D, 32'h7FFFFFFF,
                                 32'h0000ABCD, 32'h13579BDF, 32'hF0F0F0F0, 32'h00000003};

    initial begin
        int idx, npop, first, last, seen;
        bit acc, pv;
        logic [15:0] rdy_pat;
        bus.in_valid       = 1'b0;
        bus.ctrl_ALUopcode = 5'd0;
        bus.ctrl_shiftamt  = 5'd0;
        bus.data_operandA  = 32'd0;
        bus.out_ready      = 1'b0;
        #22 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data_result", bus.data_result, 32'd0);
        chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
        chk("rst_occupancy", {30'd0, bus.occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        mon_en = 1'b1;

        send_op("sll20", OP_SLL, 5'd20, 32'h77F1F54E, 32'h54E00000, 1'b0);
        send_op("sra20", OP_SRA, 5'd20, 32'h880E0AB2, 32'hFFFFF880, 1'b0);
        send_op("sra31", OP_SRA, 5'd31, 32'h77F1F54E, 32'h00000000, 1'b0);
        send_op("sra0",  OP_SRA, 5'd0,  32'h77F1F54E, 32'h77F1F54E, 1'b0);
        send_op("illeg", 5'b00000, 5'd7, 32'h12345678, 32'h12345678, 1'b1);

        // Back-pressure: 8 stalled cycles, then release and stream.
        @(posedge clock); #1;
        idx = 0; npop = 0; first = -1; last = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) begin
                chk("bp_accepted", 32'(idx), 32'd3);
                chk("bp_occupancy", {30'd0, bus.occupancy}, 32'd2);
                chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end
            bus.out_ready = (c >= 8);
            if (idx < 5) drive_req(t_op[idx], t_amt[idx], t_a[idx]);
            else bus.in_valid = 1'b0;
            @(negedge clock);
            acc = bus.in_valid && bus.in_ready;
            pv  = bus.out_valid && bus.out_ready;
            @(posedge clock); #1;
            if (acc) idx++;
            if (pv) begin
                npop++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("bp_all_accepted", 32'(idx), 32'd5);
        chk("bp_all_popped", 32'(npop), 32'd5);
        chk("bp_no_gaps", 32'(last - first), 32'd4);

        // Mixed stream under an irregular consumer.
        rdy_pat = 16'b1011_0010_1110_0101;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = (c < 16) ? rdy_pat[c] : 1'b1;
            if (idx < 8) drive_req(t_op[idx], t_amt[idx], t_a[idx]);
            else bus.in_valid = 1'b0;
            @(negedge clock);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clock); #1;
            if (acc) idx++;
        end
        chk("mix_all_accepted", 32'(idx), 32'd8);
        chk("mix_drained", {30'd0, bus.occupancy}, 32'd0);

        // Flush with 3 in flight plus a same-cycle accept and pop.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_req(OP_SLL, 5'(c + 1), 32'h00000101);
            @(posedge clock); #1;
        end
        chk("fl_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive_req(OP_SRA, 5'd2, 32'h40000000);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_occupancy", {30'd0, bus.occupancy}, 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        chk("fl_nothing_emerges", 32'(seen), 32'd0);

        // Async reset between edges with two entries queued.
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        drive_req(OP_SLL, 5'd4, 32'h0000000F);
        @(posedge clock); #1;
        drive_req(OP_SRA, 5'd4, 32'hF0000000);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        chk("ar_two_queued", {30'd0, bus.occupancy}, 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_occupancy", {30'd0, bus.occupancy}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send_op("ar_sll31", OP_SLL, 5'd31, 32'h00000001, 32'h80000000, 1'b0);

        @(posedge clock); #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/shift_stage.md
# shift_stage

Registered, flow-controlled shift pipeline stage that wraps the combinational `barrel_shifter` for the ALU datapath. It accepts operand, opcode and shift amount over a valid/ready handshake and captures them in an input register. It then evaluates SLL/SRA through the shifter and buffers results in a 2-entry output FIFO, so downstream back-pressure never corrupts or drops in-flight operations. The stage sits between operand fetch/decode and the ALU result mux.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (fixed; the shifter is 32-bit only).
- `FIFO_DEPTH`, 2, output buffer entries (fixed; the counter is 2 bits).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flush`  in  1  synchronous; discards everything in flight at the next edge.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept this cycle.
- `ctrl_ALUopcode`  in  5  `OP_SLL`=5'b00100, `OP_SRA`=5'b00101; any other value is illegal.
- `ctrl_shiftamt`  in  5  shift amount, 0–31.
- `data_operandA`  in  32  operand to shift.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `data_result`  out  32  FIFO head result.
- `out_illegal`  out  1  head came from an illegal opcode.
- `occupancy`  out  2  FIFO entry count, 0–2.

## Operation
- Accept: `in_valid && in_ready` at an edge loads S1: operand, amount, `left` (opcode==`OP_SLL`), illegal flag, and sets `s1_valid`.
- Evaluate: S1 drives `barrel_shifter`. SLL shifts left and zero-fills. SRA shifts right and fills with the sign bit. An illegal opcode passes the operand unchanged, with shift amount forced to 0 and illegal=1.
- Advance: S1 writes into the FIFO tail when `s1_valid && (occupancy<2 || pop)`, where `pop = out_valid && out_ready`.
- `in_ready = !s1_valid || occupancy<2 || pop`. There is a combinational path from `out_ready` to `in_ready`; this path is intended.
- FIFO state:
  - Read and write pointers are 1 bit each and wrap 1→0.
  - Simultaneous push and pop at `occupancy`==2 is legal; occupancy stays at 2.
  - Push and pop together at `occupancy`==0 is impossible, because `out_valid`=0.
- Ordering: strict FIFO. No reordering, duplication or loss under any back-pressure pattern.
- `flush`: at the next edge, `s1_valid`=0, pointers=0 and `occupancy`=0. A same-cycle accept or pop is discarded/ignored.
- Reset values: `s1_valid`=0, `occupancy`=0, `out_valid`=0, `data_result`=0, `out_illegal`=0, pointers 0. After reset, `in_ready`=1.
- Reset asserted mid-operation drops all in-flight data, with no partial results. The first accept happens at the first edge after deassertion.

## Timing
- Latency: request accepted at edge k → in FIFO at edge k+1 → `out_valid`=1 during cycle k+1. This holds when the FIFO is not full.
- Throughput: 1 op/cycle sustained while `out_ready`=1.
- Capacity: 3 in flight (S1 plus 2 FIFO entries). With `out_ready` held low, exactly 3 requests are accepted and `in_ready` then stays 0.
- Outputs `data_result` and `out_illegal` are read from FIFO registers, never from the shifter directly. They are stable while `out_valid && !out_ready`.
- `flush` and `reset` both take priority over all other events in the same cycle; `reset` takes priority over `flush`.

## Structure
- Shared package `alu_pkg`: `OP_SLL`, `OP_SRA`, `WIDTH`. The future ALU opcode constants live there as well.
- Sub-module: the existing `barrel_shifter(out, in, shiftamt, left)`, instantiated unchanged.
- The FIFO and S1 are coded inline in this module; no further hierarchy.

## Test plan
- SLL: operand 0x77F1F54E, amount 20, opcode 00100 → `data_result`=0x54E00000, `out_illegal`=0, with `out_valid` one cycle after the accept edge.
- SRA:
  - 0x880E0AB2 by 20 → 0xFFFFF880.
  - 0x77F1F54E by 31 → 0x00000000.
  - 0x77F1F54E by 0 → 0x77F1F54E.
- Illegal opcode 00000, operand 0x12345678, amount 7 → `data_result`=0x12345678, `out_illegal`=1.
- Back-pressure:
  - Hold `out_ready`=0 and offer 5 back-to-back requests → exactly 3 accepted, `occupancy`=2, `in_ready`=0.
  - Release `out_ready` → all 5 results in order, no gaps once streaming.
- Flush with 3 in flight plus a same-cycle `in_valid` → next cycle `out_valid`=0, `occupancy`=0, and none of the 4 ever appear.
- Async reset asserted between edges with 2 entries queued → `out_valid`=0 immediately. After release, a fresh SLL of 1 by 31 → 0x80000000.
